fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Round-robin, burst-capable arbiter that lets `NUM_REQ` producers share the push port of a single `FIFO` instance. It sits directly in front of the FIFO's `push_data_i` / `push_valid_i` / `push_grant_o` interface. Each producer sees its own valid/grant handshake. A winning producer may hold the FIFO for up to `MAX_BURST` consecutive transfers before ownership rotates.

## Interface
- `NUM_REQ`, default 4: number of producers; any value ≥ 2, power of two not required.
- `DATA_WIDTH`, default 32: data buses are `DATA_WIDTH+1` bits (`[DATA_WIDTH:0]`), matching the FIFO.
- `MAX_BURST`, default 4: maximum transfers per ownership tenure; ≥ 1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  `NUM_REQ`  producer i has a word to push.
- `req_data_i`  in  `NUM_REQ*(DATA_WIDTH+1)`  producer i's word in slice i.
- `req_grant_o`  out  `NUM_REQ`  one-hot or zero; the word from producer i is consumed this cycle.
- `push_data_o`  out  `DATA_WIDTH+1`  to FIFO `push_data_i`.
- `push_valid_o`  out  1  to FIFO `push_valid_i`.
- `push_grant_i`  in  1  from FIFO `push_grant_o` (not full).
- `owner_o`  out  `$clog2(NUM_REQ)`  index of the selected producer; meaningful only when `push_valid_o` = 1.
- `busy_o`  out  1  FSM is in `OWNED`.

## Operation
- **Registered state:** `state` ∈ {`IDLE`, `OWNED`}, `rr_ptr`, `owner`, `beat_cnt` (`$clog2(MAX_BURST+1)` bits).
- **Selection in `IDLE`:**
  - `sel` is the first i with `req_valid_i[i]` = 1, searching `rr_ptr`, `rr_ptr+1`, … with wrap modulo `NUM_REQ`.
  - `push_valid_o` = any request valid.
- **Selection in `OWNED`:** `sel` = `owner` and `push_valid_o` = `req_valid_i[owner]`.
- **Datapath:**
  - `push_data_o` = slice `sel` of `req_data_i`; it is 0 when `push_valid_o` = 0.
  - `owner_o` = `sel`.
  - `req_grant_o[i]` = `push_valid_o` && `push_grant_i` && (i == `sel`).
  - A transfer (xfer) occurs when `push_valid_o` && `push_grant_i`.
- **`IDLE` transitions:**
  - No request: stay in `IDLE`.
  - Request with xfer, and `MAX_BURST` == 1: stay in `IDLE`; `rr_ptr` ← `sel+1` (mod `NUM_REQ`).
  - Request with xfer, and `MAX_BURST` > 1: go to `OWNED`; `owner` ← `sel`; `beat_cnt` ← 1.
  - Request without xfer (FIFO full): go to `OWNED`; `owner` ← `sel`; `beat_cnt` ← 0. This locks the choice so a late-arriving producer cannot steal the slot.
- **`OWNED` transitions:**
  - xfer with `beat_cnt`+1 == `MAX_BURST`: release, meaning `IDLE`, `rr_ptr` ← `owner+1`, `beat_cnt` ← 0.
  - xfer otherwise: `beat_cnt` ← `beat_cnt`+1.
  - `req_valid_i[owner]` = 0: release the same way. No transfer happens in that cycle.
  - Valid with `push_grant_i` = 0: hold all state.
- **Producer rule:** a producer keeps its valid and data stable until granted. The arbiter never drops a selected-and-valid producer except through the release conditions above.

## Timing
- Zero-cycle grant path: `req_grant_o` and `push_*` are combinational from `req_valid_i`, `push_grant_i` and registered state.
- State updates on `posedge clk`.
- **Reset (asynchronous):**
  - `state` = `IDLE`, `rr_ptr` = 0, `owner` = 0, `beat_cnt` = 0.
  - While `rst_n` = 0, all outputs are forced to 0: `req_grant_o`, `push_valid_o`, `push_data_o`, `owner_o`, `busy_o`.
- **Reset mid-burst:** the tenure is abandoned. After release of reset, arbitration restarts from producer 0.
- **Throughput:**
  - One word per cycle while `push_grant_i` = 1.
  - Release via an owner dropping valid costs one idle cycle.
  - Release via the `MAX_BURST` limit costs none: the next owner is selected in the following cycle.
- **Wrap-around:** `rr_ptr` = `NUM_REQ-1` advances to 0.

## Structure
- **Package `fifo_arb_pkg`:** contains the `arb_state_t` enum {`IDLE`, `OWNED`} and a `rr_next(ptr, n)` modulo-increment function.
- **Sub-module `rr_picker`:** combinational; inputs are the request vector and the pointer; outputs are `found` and `idx`.
  - It is reused by later pop-side schedulers.
  - It is instantiated once here, for the `IDLE` search.
- **Integration:** the top level wires `push_data_o`, `push_valid_o` and `push_grant_i` to the `FIFO` instance.

## Test plan
- **Reset:** with `rst_n` = 0 and all `req_valid_i` = 4'b1111, all outputs = 0. After release, the first grant goes to producer 0.
- **Burst limit:** `MAX_BURST` = 4, producers 0 and 2 continuously valid, `push_grant_i` = 1 → grants 0,0,0,0,2,2,2,2,0,… with no gap cycles.
- **Early release:** producer 1 drops valid after 2 beats while producer 3 is valid → one cycle with `push_valid_o` = 0, then producer 3 is granted and `rr_ptr` = 2 before that selection.
- **Lock on full FIFO:** `push_grant_i` = 0 with producer 2 valid in `IDLE` → `busy_o` = 1 and `owner_o` = 2. Raising producer 1 while full does not change `owner_o`. Once `push_grant_i` = 1, producer 2 is granted first.
- **Single-beat rotation:** `MAX_BURST` = 1, `NUM_REQ` = 3, all valid → grants 0,1,2,0,1,2; `busy_o` stays 0.
- **Async reset mid-burst:** assert `rst_n` low mid-burst at beat 2 of producer 3 → outputs go to 0 immediately. After release, the grant order restarts at producer 0 with `beat_cnt` = 0.

Source files
------------

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO push-side arbiter and later pop-side schedulers.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   // Modulo-n increment, used to advance the round-robin pointer past a retiring owner.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-facing and FIFO-facing handshake bundle of the push arbiter.
interface fifo_push_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]                  req_valid_i;
   logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_data_i;
   logic [NUM_REQ-1:0]                  req_grant_o;
   logic [DATA_WIDTH:0]                 push_data_o;
   logic                                push_valid_o;
   logic                                push_grant_i;
   logic [$clog2(NUM_REQ)-1:0]          owner_o;
   logic                                busy_o;

   // The arbiter is the master; producers, the FIFO and observers take the slave side.
   modport master (
      input  req_valid_i, req_data_i, push_grant_i,
      output req_grant_o, push_data_o, push_valid_o, owner_o, busy_o
   );

   modport slave (
      output req_valid_i, req_data_i, push_grant_i,
      input  req_grant_o, push_data_o, push_valid_o, owner_o, busy_o
   );
endinterface

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, with wrap.
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]          i_req,
   input  logic [$clog2(N)-1:0]  i_ptr,
   output logic                  o_found,
   output logic [$clog2(N)-1:0]  o_idx
);
   localparam int IW = $clog2(N);

   function automatic int wrapIdx(input logic [IW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      return (s >= N) ? s - N : s;
   endfunction

   // Scan from the farthest offset down so the nearest request to the pointer wins.
   always_comb begin
      o_found = |i_req;
      o_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[wrapIdx(i_ptr, k)]) o_idx = IW'(wrapIdx(i_ptr, k));
      end
   end
endmodule

// File: rtl/fifo_push_arbiter.sv
// Burst-capable round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input logic                clk,
   input logic                rst_n,
   fifo_push_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t        r_state;
   logic [IDX_W-1:0]  r_rrPtr;
   logic [IDX_W-1:0]  r_owner;
   logic [CNT_W-1:0]  r_beatCnt;

   logic              w_found;
   logic [IDX_W-1:0]  w_pickIdx;
   logic [IDX_W-1:0]  w_sel;
   logic              w_valid;
   logic              w_xfer;
   logic [DATA_WIDTH:0] w_data;

   rr_picker #(.N(NUM_REQ)) u_picker (
      .i_req   (bus.req_valid_i),
      .i_ptr   (r_rrPtr),
      .o_found (w_found),
      .o_idx   (w_pickIdx)
   );

   // An owner keeps the port until it drops valid or exhausts its burst allowance.
   always_comb begin
      w_sel   = (r_state == OWNED) ? r_owner : w_pickIdx;
      w_valid = (r_state == OWNED) ? bus.req_valid_i[r_owner] : w_found;
      w_xfer  = w_valid && bus.push_grant_i;
      w_data  = bus.req_data_i[w_sel*(DATA_WIDTH+1) +: (DATA_WIDTH+1)];
   end

   always_comb begin
      bus.req_grant_o  = '0;
      bus.push_valid_o = 1'b0;
      bus.push_data_o  = '0;
      bus.owner_o      = '0;
      bus.busy_o       = 1'b0;
      if (rst_n) begin
         bus.push_valid_o = w_valid;
         bus.owner_o      = w_sel;
         bus.busy_o       = (r_state == OWNED);
         if (w_valid) bus.push_data_o = w_data;
         if (w_xfer)  bus.req_grant_o = NUM_REQ'(1) << w_sel;
      end
   end

   // A selection that stalls on a full FIFO is locked into OWNED so a later requester cannot steal it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rrPtr   <= '0;
         r_owner   <= '0;
         r_beatCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  if (!w_xfer) begin
                     r_state   <= OWNED;
                     r_owner   <= w_sel;
                     r_beatCnt <= '0;
                  end else if (MAX_BURST == 1) begin
                     r_rrPtr <= IDX_W'(rr_next(int'(w_sel), NUM_REQ));
                  end else begin
                     r_state   <= OWNED;
                     r_owner   <= w_sel;
                     r_beatCnt <= CNT_W'(1);
                  end
               end
            end
            OWNED: begin
               if (!bus.req_valid_i[r_owner] ||
                   (w_xfer && (int'(r_beatCnt) + 1 == MAX_BURST))) begin
                  r_state   <= IDLE;
                  r_rrPtr   <= IDX_W'(rr_next(int'(r_owner), NUM_REQ));
                  r_beatCnt <= '0;
               end else if (w_xfer) begin
                  r_beatCnt <= r_beatCnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench: a 4-producer/burst-4 arbiter and a 3-producer/single-beat arbiter.
module tb_fifo_push_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   expQ[$];

   always #5 clk = ~clk;

   fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) busA ();
   fifo_push_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8))  busB ();

   fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dutA (
      .clk(clk), .rst_n(rst_n), .bus(busA.master));
   fifo_push_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dutB (
      .clk(clk), .rst_n(rst_n), .bus(busB.master));

   function automatic logic [32:0] dataA(input int i);
      return {1'b1, 32'hC0DE_0000 + 32'(i)};
   endfunction

   function automatic logic [8:0] dataB(input int i);
      return {1'b0, 8'h50 + 8'(i)};
   endfunction

   // Decodes a grant vector: -1 for none, index for one-hot, -2 for anything illegal.
   function automatic int grantIdx(input logic [3:0] g);
      if (g == 4'b0000) return -1;
      for (int i = 0; i < 4; i++) if (g == (4'b0001 << i)) return i;
      return -2;
   endfunction

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      busA.req_valid_i = 4'b1111;
      busA.push_grant_i = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      total++; if (busA.req_grant_o !== 4'b0) begin bad++; $display("[TB] FAIL reset_grant: got %b want 0000", busA.req_grant_o); end
      total++; if (busA.push_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", busA.push_valid_o); end
      total++; if (busA.push_data_o !== 33'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", busA.push_data_o); end
      total++; if (busA.owner_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_owner: got %0d want 0", busA.owner_o); end
      total++; if (busA.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busA.busy_o); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (busA.req_grant_o !== 4'b0001) begin bad++; $display("[TB] FAIL reset_first_grant: got %b want 0001", busA.req_grant_o); end
      total++; if (busA.push_data_o !== dataA(0)) begin bad++; $display("[TB] FAIL reset_first_data: got %h want %h", busA.push_data_o, dataA(0)); end
      @(negedge clk);
      busA.req_valid_i = 4'b0000;
   endtask

   task automatic test_burst_limit();
      int seq[12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
      int exp, got;
      doReset();
      busA.push_grant_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         busA.req_valid_i = 4'b0101;
         expQ.push_back(seq[c]);
         #1;
         got = grantIdx(busA.req_grant_o);
         exp = expQ.pop_front();
         total++; if (got !== exp) begin bad++; $display("[TB] FAIL burst_grant[%0d]: got %0d want %0d", c, got, exp); end
         total++; if (busA.push_data_o !== dataA(exp)) begin bad++; $display("[TB] FAIL burst_data[%0d]: got %h want %h", c, busA.push_data_o, dataA(exp)); end
         @(negedge clk);
      end
      busA.req_valid_i = 4'b0000;
   endtask

   task automatic test_early_release();
      logic [3:0] vec[4] = '{4'b1010, 4'b1010, 4'b1000, 4'b1000};
      int seq[4] = '{1, 1, -1, 3};
      int exp, got;
      doReset();
      busA.push_grant_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         busA.req_valid_i = vec[c];
         expQ.push_back(seq[c]);
         #1;
         if (c == 3) begin
            total++; if (dutA.r_rrPtr !== 2'd2) begin bad++; $display("[TB] FAIL early_rr_ptr: got %0d want 2", dutA.r_rrPtr); end
         end
         got = grantIdx(busA.req_grant_o);
         exp = expQ.pop_front();
         total++; if (got !== exp) begin bad++; $display("[TB] FAIL early_grant[%0d]: got %0d want %0d", c, got, exp); end
         total++; if (busA.push_valid_o !== (exp >= 0)) begin bad++; $display("[TB] FAIL early_valid[%0d]: got %b want %b", c, busA.push_valid_o, exp >= 0); end
         @(negedge clk);
      end
      busA.req_valid_i = 4'b0000;
   endtask

   task automatic test_lock_full();
      logic [3:0] vec[3]  = '{4'b0100, 4'b0110, 4'b0110};
      logic       gnt[3]  = '{1'b0, 1'b0, 1'b1};
      int         seq[3]  = '{-1, -1, 2};
      logic       busy[3] = '{1'b0, 1'b1, 1'b1};
      int exp, got;
      doReset();
      for (int c = 0; c < 3; c++) begin
         busA.req_valid_i = vec[c];
         busA.push_grant_i = gnt[c];
         expQ.push_back(seq[c]);
         #1;
         got = grantIdx(busA.req_grant_o);
         exp = expQ.pop_front();
         total++; if (got !== exp) begin bad++; $display("[TB] FAIL lock_grant[%0d]: got %0d want %0d", c, got, exp); end
         total++; if (busA.owner_o !== 2'd2) begin bad++; $display("[TB] FAIL lock_owner[%0d]: got %0d want 2", c, busA.owner_o); end
         total++; if (busA.busy_o !== busy[c]) begin bad++; $display("[TB] FAIL lock_busy[%0d]: got %b want %b", c, busA.busy_o, busy[c]); end
         @(negedge clk);
      end
      busA.req_valid_i = 4'b0000;
   endtask

   task automatic test_single_beat();
      int seq[6] = '{0, 1, 2, 0, 1, 2};
      int exp, got;
      doReset();
      busB.push_grant_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         busB.req_valid_i = 3'b111;
         expQ.push_back(seq[c]);
         #1;
         got = grantIdx({1'b0, busB.req_grant_o});
         exp = expQ.pop_front();
         total++; if (got !== exp) begin bad++; $display("[TB] FAIL single_grant[%0d]: got %0d want %0d", c, got, exp); end
         total++; if (busB.push_data_o !== dataB(exp)) begin bad++; $display("[TB] FAIL single_data[%0d]: got %h want %h", c, busB.push_data_o, dataB(exp)); end
         total++; if (busB.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL single_busy[%0d]: got %b want 0", c, busB.busy_o); end
         @(negedge clk);
      end
      busB.req_valid_i = 3'b000;
   endtask

   task automatic test_reset_mid_burst();
      int got;
      doReset();
      busA.push_grant_i = 1'b1;
      busA.req_valid_i = 4'b1000;
      for (int c = 0; c < 2; c++) begin
         expQ.push_back(3);
         #1;
         got = grantIdx(busA.req_grant_o);
         total++; if (got !== expQ.pop_front()) begin bad++; $display("[TB] FAIL midrst_grant[%0d]: got %0d want 3", c, got); end
         @(negedge clk);
      end
      #1;
      total++; if (dutA.r_beatCnt !== 3'd2) begin bad++; $display("[TB] FAIL midrst_beat_pre: got %0d want 2", dutA.r_beatCnt); end
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (busA.req_grant_o !== 4'b0) begin bad++; $display("[TB] FAIL midrst_grant_zero: got %b want 0000", busA.req_grant_o); end
      total++; if (busA.push_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid_zero: got %b want 0", busA.push_valid_o); end
      total++; if (busA.push_data_o !== 33'h0) begin bad++; $display("[TB] FAIL midrst_data_zero: got %h want 0", busA.push_data_o); end
      total++; if (busA.owner_o !== 2'd0 || busA.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_owner_busy: got %0d/%b want 0/0", busA.owner_o, busA.busy_o); end
      total++; if (dutA.r_beatCnt !== 3'd0) begin bad++; $display("[TB] FAIL midrst_beat_post: got %0d want 0", dutA.r_beatCnt); end
      @(negedge clk);
      rst_n = 1'b1;
      busA.req_valid_i = 4'b1111;
      expQ.push_back(0);
      #1;
      got = grantIdx(busA.req_grant_o);
      total++; if (got !== expQ.pop_front()) begin bad++; $display("[TB] FAIL midrst_restart: got %0d want 0", got); end
      @(negedge clk);
      busA.req_valid_i = 4'b0000;
   endtask

   initial begin
      busA.req_valid_i  = '0;
      busA.push_grant_i = 1'b0;
      busB.req_valid_i  = '0;
      busB.push_grant_i = 1'b0;
      for (int i = 0; i < 4; i++) busA.req_data_i[i*33 +: 33] = dataA(i);
      for (int i = 0; i < 3; i++) busB.req_data_i[i*9 +: 9] = dataB(i);
      test_reset();
      test_burst_limit();
      test_early_release();
      test_lock_full();
      test_single_beat();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
